// File: rtl/valid_beat_counter.sv
// Beat counter for the FFT datapath: counts valid beats up to a threshold
// latched at start, with one-shot (hold) and auto-reload (wrap) modes.
module valid_beat_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             valid,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             not_zero,
    output logic             full,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             terminal;

    // thr_q is never 0 while in RUN, so thr_q-1 cannot underflow there
    assign terminal = (cnt_q == (thr_q - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            thr_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else if (start) begin
            cnt_d  = '0;
            ovr_d  = 1'b0;
            thr_d  = thresh;
            mode_d = auto_reload;
            if (thresh == '0) begin
                state_d = HOLD;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (valid) begin
            unique case (state_q)
                IDLE: cnt_d = '0;
                RUN: begin
                    if (terminal) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d   = thr_q;
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                HOLD: ovr_d = 1'b1;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign cnt      = cnt_q;
    assign busy     = (state_q == RUN);
    assign full     = (state_q == HOLD);
    assign not_zero = (cnt_q != '0);
    assign done     = done_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_valid_beat_counter.sv
// Directed table-driven bench for valid_beat_counter (WIDTH=7)
// plus hand-written sequences for reset and full-range corners.
module tb_valid_beat_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] thresh;
    logic       start, stop, valid, auto_reload;
    logic [6:0] cnt;
    logic       busy, not_zero, full, done, overrun;

    int tests = 0;
    int fails = 0;

    valid_beat_counter #(.WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n), .thresh(thresh), .start(start),
        .stop(stop), .valid(valid), .auto_reload(auto_reload),
        .cnt(cnt), .busy(busy), .not_zero(not_zero), .full(full),
        .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       st, sp, vl, ar;
        logic [6:0] th;
        logic [6:0] ec;
        logic       eb, ef, ed, eo;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic st, sp, vl,
                       input logic [6:0] th, input logic ar,
                       input logic [6:0] ec, input logic eb, ef, ed, eo);
        vec_t v;
        v.name = n; v.st = st; v.sp = sp; v.vl = vl; v.th = th; v.ar = ar;
        v.ec = ec; v.eb = eb; v.ef = ef; v.ed = ed; v.eo = eo;
        vq.push_back(v);
    endtask

    // expected bundle order: cnt, busy, not_zero, full, done, overrun
    task automatic check(input string n, input logic [6:0] ec,
                         input logic eb, ef, ed, eo);
        logic [11:0] got, exp;
        got = {cnt, busy, not_zero, full, done, overrun};
        exp = {ec, eb, (ec != 7'd0), ef, ed, eo};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got cnt=%0d b=%b nz=%b f=%b d=%b o=%b, want cnt=%0d b=%b nz=%b f=%b d=%b o=%b",
                     n, got[11:5], got[4], got[3], got[2], got[1], got[0],
                     exp[11:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic st, sp, vl,
                         input logic [6:0] th, input logic ar);
        start = st; stop = sp; valid = vl; thresh = th; auto_reload = ar;
    endtask

    task automatic step(input logic st, sp, vl,
                        input logic [6:0] th, input logic ar);
        drive(st, sp, vl, th, ar);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 7'd0, 0);

        // one-shot, thresh 5, 7 valids
        add("os_start", 1,0,0, 5,0,  0,1,0,0,0);
        add("os_v1",    0,0,1, 5,0,  1,1,0,0,0);
        add("os_v2",    0,0,1, 5,0,  2,1,0,0,0);
        add("os_v3",    0,0,1, 5,0,  3,1,0,0,0);
        add("os_v4",    0,0,1, 5,0,  4,1,0,0,0);
        add("os_v5",    0,0,1, 5,0,  5,0,1,1,0);
        add("os_v6",    0,0,1, 5,0,  5,0,1,0,1);
        add("os_v7",    0,0,1, 5,0,  5,0,1,0,1);
        add("os_idle",  0,0,0, 5,0,  5,0,1,0,1);
        // auto-reload, thresh 4, 12 valids
        add("ar_start", 1,0,0, 4,1,  0,1,0,0,0);
        for (int i = 1; i <= 12; i++)
            add($sformatf("ar_v%0d", i), 0,0,1, 4,1,
                7'(i % 4), 1, 0, (i % 4) == 0, 0);
        add("ar_gap",   0,0,0, 4,1,  0,1,0,0,0);
        // zero threshold goes straight to HOLD with done
        add("z_start",  1,0,0, 0,1,  0,0,1,1,0);
        add("z_after",  0,0,0, 0,1,  0,0,1,0,0);
        add("z_valid",  0,0,1, 0,1,  0,0,1,0,1);
        // threshold change mid-run has no effect
        add("th_start", 1,0,0, 6,0,  0,1,0,0,0);
        add("th_v1",    0,0,1, 6,0,  1,1,0,0,0);
        add("th_v2",    0,0,1, 6,0,  2,1,0,0,0);
        add("th_v3",    0,0,1, 6,0,  3,1,0,0,0);
        add("th_v4",    0,0,1, 2,1,  4,1,0,0,0);
        add("th_v5",    0,0,1, 2,1,  5,1,0,0,0);
        add("th_v6",    0,0,1, 2,1,  6,0,1,1,0);
        add("th_rst2",  1,0,0, 2,0,  0,1,0,0,0);
        add("th_r1",    0,0,1, 9,1,  1,1,0,0,0);
        add("th_r2",    0,0,1, 9,1,  2,0,1,1,0);
        // stop > start > valid
        add("p_start",  1,0,0, 10,0, 0,1,0,0,0);
        add("p_v1",     0,0,1, 10,0, 1,1,0,0,0);
        add("p_v2",     0,0,1, 10,0, 2,1,0,0,0);
        add("p_v3",     0,0,1, 10,0, 3,1,0,0,0);
        add("p_all",    1,1,1, 10,0, 0,0,0,0,0);
        add("p_idle_v", 0,0,1, 10,0, 0,0,0,0,0);
        add("p_st_v",   1,0,1, 10,0, 0,1,0,0,0);
        // stop on the would-be terminal beat: no done
        add("s_start",  1,0,0, 2,0,  0,1,0,0,0);
        add("s_v1",     0,0,1, 2,0,  1,1,0,0,0);
        add("s_stopv",  0,1,1, 2,0,  0,0,0,0,0);
        // back-to-back starts
        add("b_s1",     1,0,1, 3,0,  0,1,0,0,0);
        add("b_v",      0,0,1, 3,0,  1,1,0,0,0);
        add("b_s2",     1,0,1, 3,0,  0,1,0,0,0);
        add("b_s3",     1,0,0, 3,0,  0,1,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].st, vq[i].sp, vq[i].vl, vq[i].th, vq[i].ar);
            check(vq[i].name, vq[i].ec, vq[i].eb, vq[i].ef,
                  vq[i].ed, vq[i].eo);
        end

        // asynchronous reset at cnt=100, thresh=127
        step(1, 0, 0, 7'd127, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 1, 7'd127, 0);
        check("cnt100", 100, 1, 0, 0, 0);
        drive(0, 0, 0, 7'd127, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 7'd127, 0);
        check("rst_valid_only", 0, 0, 0, 0, 0);

        // full-range threshold 127, one-shot
        step(1, 0, 0, 7'd127, 0);
        for (int i = 0; i < 126; i++) step(0, 0, 1, 7'd127, 0);
        check("max_126", 126, 1, 0, 0, 0);
        step(0, 0, 1, 7'd127, 0);
        check("max_term", 127, 0, 1, 1, 0);
        step(0, 0, 0, 7'd127, 0);
        check("max_hold", 127, 0, 1, 0, 0);

        // auto-reload full range: done period 127
        step(1, 0, 0, 7'd127, 1);
        for (int i = 0; i < 126; i++) step(0, 0, 1, 7'd127, 1);
        step(0, 0, 1, 7'd127, 1);
        check("armax_wrap", 0, 1, 0, 1, 0);
        step(0, 0, 1, 7'd127, 1);
        check("armax_next", 1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
